// File: rtl/gpr_pkg.sv
// gpr_pkg: shared constants and read-select helper for the multi-port register file
package gpr_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO = 0;
  localparam int GP_IDX_DEF = 28;
  localparam logic [31:0] GP_INIT_DEF = 32'h0000_1800;
  localparam int SP_IDX_DEF = 29;
  localparam logic [31:0] SP_INIT_DEF = 32'h0000_2FFC;
  typedef enum logic [1:0] {RS_ZERO, RS_W1, RS_W0, RS_MEM} rsel_e;
  function automatic rsel_e rd_sel(input logic zero, input logic hit1, input logic hit0);
    return zero ? RS_ZERO : hit1 ? RS_W1 : hit0 ? RS_W0 : RS_MEM;
  endfunction
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register busy bits (set beats clear) with per-read-port lookup
module gpr_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bset,
  input  logic [ADDR_W-1:0]        baddr,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD-1:0]        rbusy,
  output logic                     busy_any
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DEPTH-1:0] busy, set_v, clr_v;
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (bset) set_v[baddr] = 1'b1;
    if (we0) clr_v[wa0] = 1'b1;
    if (we1) clr_v[wa1] = 1'b1;
  end
  // register 0 is masked so it can never appear busy
  always_ff @(posedge clk)
    if (rst) busy <= '0;
    else busy <= (set_v | (busy & ~clr_v)) & ~DEPTH'(1);
  assign busy_any = |busy;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rb
    logic [ADDR_W-1:0] a;
    assign a = ra[k*ADDR_W +: ADDR_W];
    assign rbusy[k] = a != '0 && busy[a] && !(BYPASS != 0 && clr_v[a]);
  end
endmodule

// File: rtl/gpr_mp.sv
// gpr_mp: multi-port GPR file with dual write, optional bypass and busy scoreboard.
// Define GPR_MP_TRACE_EN to print every committed write.
module gpr_mp import gpr_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int GP_IDX = GP_IDX_DEF,
  parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(GP_INIT_DEF),
  parameter int SP_IDX = SP_IDX_DEF,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF),
  parameter int BYPASS = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_RD*ADDR_W-1:0] Ra,
  output logic [NUM_RD*DATA_W-1:0] Rd,
  output logic [NUM_RD-1:0]        Rbusy,
  input  logic                     We0,
  input  logic [ADDR_W-1:0]        Wa0,
  input  logic [DATA_W-1:0]        Wd0,
  input  logic                     We1,
  input  logic [ADDR_W-1:0]        Wa1,
  input  logic [DATA_W-1:0]        Wd1,
  input  logic                     Bset,
  input  logic [ADDR_W-1:0]        Baddr,
  output logic                     Busy_any
);
  localparam int DEPTH = 1 << ADDR_W;
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("gpr_mp: NUM_RD must be in 1..4");
  end
  logic [DATA_W-1:0] regs [DEPTH];
  // port 1 is written last so it wins a same-address collision
  always_ff @(posedge Clk)
    if (Rst) for (int i = 0; i < DEPTH; i++) regs[i] <= i == GP_IDX ? GP_INIT : i == SP_IDX ? SP_INIT : '0;
    else begin
      if (We0 && Wa0 != ADDR_W'(REG_ZERO)) regs[Wa0] <= Wd0;
      if (We1 && Wa1 != ADDR_W'(REG_ZERO)) regs[Wa1] <= Wd1;
    end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    rsel_e s;
    assign a = Ra[k*ADDR_W +: ADDR_W];
    assign s = rd_sel(a == ADDR_W'(REG_ZERO), BYPASS != 0 && We1 && Wa1 == a, BYPASS != 0 && We0 && Wa0 == a);
    assign Rd[k*DATA_W +: DATA_W] = s == RS_ZERO ? '0 : s == RS_W1 ? Wd1 : s == RS_W0 ? Wd0 : regs[a];
  end
  gpr_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .BYPASS(BYPASS)) u_sb (
    .clk(Clk), .rst(Rst), .bset(Bset), .baddr(Baddr),
    .we0(We0), .wa0(Wa0), .we1(We1), .wa1(Wa1),
    .ra(Ra), .rbusy(Rbusy), .busy_any(Busy_any)
  );
`ifdef GPR_MP_TRACE_EN
  always_ff @(posedge Clk)
    if (!Rst) begin
      if (We0 && Wa0 != ADDR_W'(REG_ZERO) && !(We1 && Wa1 == Wa0)) $display("%0t gpr_mp: port 0 r%0d = %h", $time, Wa0, Wd0);
      if (We1 && Wa1 != ADDR_W'(REG_ZERO)) $display("%0t gpr_mp: port 1 r%0d = %h", $time, Wa1, Wd1);
    end
`endif
endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the single-write, two-read GPR in the pipelined MIPS core.
- Adds configurable width, depth and read-port count, plus a second write port with defined priority.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard for the hazard unit.
- Sits in the ID stage: read ports feed operand muxes, write ports come from WB (and a late-result path), busy bits feed stall logic.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth is 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).
- GP_IDX, 28, index of register loaded with GP_INIT at reset.
- GP_INIT, 32'h0000_1800, reset value of register GP_IDX.
- SP_IDX, 29, index of register loaded with SP_INIT at reset.
- SP_INIT, 32'h0000_2FFC, reset value of register SP_IDX.
- BYPASS, 1, 1 = a read of a register written this cycle returns the write data; 0 = returns the stored value.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous active-high reset.
- Ra  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- Rd  out  NUM_RD*DATA_W  packed read data, port k uses [k*DATA_W +: DATA_W]; combinational.
- Rbusy  out  NUM_RD  busy bit of the register addressed by each read port; combinational.
- We0  in  1  write enable, port 0 (WB stage).
- Wa0  in  ADDR_W  write address, port 0.
- Wd0  in  DATA_W  write data, port 0.
- We1  in  1  write enable, port 1 (late-result path).
- Wa1  in  ADDR_W  write address, port 1.
- Wd1  in  DATA_W  write data, port 1.
- Bset  in  1  mark register Baddr busy (producer issued).
- Baddr  in  ADDR_W  register to mark busy.
- Busy_any  out  1  OR of all busy bits; registered state, no combinational path from inputs.

Behaviour:
- Reset (Rst=1 at a rising edge):
  - All registers load 0, except GP_IDX = GP_INIT and SP_IDX = SP_INIT.
  - All busy bits clear.
  - Any write or Bset in the same cycle is ignored.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to it and Bset targeting it are discarded.
- Writes take effect at the rising edge; the stored value is visible on Rd in the next cycle.
- Dual write, same address, both enabled: port 1 wins. Different addresses: both commit.
- Read data, per port k:
  - Address 0 -> 0.
  - Else if BYPASS and We1 and Wa1==addr -> Wd1.
  - Else if BYPASS and We0 and Wa0==addr -> Wd0.
  - Else the stored value.
- Scoreboard, one busy bit per register:
  - Set at the edge when Bset=1.
  - Cleared at the edge when any enabled write targets that register.
  - Set and clear on the same register in the same cycle: set wins (new producer supersedes).
- Rbusy[k]:
  - Is the stored busy bit of Ra port k, ANDed with NOT (BYPASS and an enabled write to that address this cycle).
  - Forced to 0 for address 0.
- Latency: read 0 cycles (combinational); write 1 edge; busy set/clear 1 edge.
- Out-of-range NUM_RD is a compile-time error (generate-time check).

Optional Feature:
- Macro GPR_MP_TRACE_EN.
- Defined: each committed write prints simulation time, port number, register index and data in hex.
  - Same-address dual write prints only the winning port.
  - Writes to register 0 do not print.
- Undefined: no display statements are compiled; behaviour is otherwise identical.

Decomposition:
- Shared package gpr_pkg holds:
  - REG_ZERO, GP_IDX, SP_IDX and their init constants.
  - The DATA_W/ADDR_W defaults.
  - A function computing the bypass-resolved read value.
- One natural sub-module: gpr_scoreboard (busy-bit array with set/clear priority and Rbusy lookup), instantiated once.

Test Plan:
- Reset: Rst=1 for one edge -> read r28=0x1800, r29=0x2FFC, r5=0, Busy_any=0; We0 to r5 during reset -> r5 still 0.
- Basic and r0:
  - We0 r5=0xDEADBEEF -> next cycle Rd[r5]=0xDEADBEEF.
  - We0 r0=0x1234 -> Rd[r0]=0.
- Dual-write collision: We0 r7=0x11, We1 r7=0x22 same cycle -> r7=0x22. Different addresses r7/r8 -> both commit.
- Bypass (BYPASS=1): write r9=0xABCD while Ra0=r9 -> Rd0=0xABCD same cycle. BYPASS=0 bench: Rd0 shows the old value until the next cycle.
- Scoreboard sequence:
  - Bset r10 -> next cycle Rbusy for r10 = 1 and Busy_any=1.
  - We0 r10 -> Rbusy=0 during the write cycle (bypass) and after.
  - Bset r10 with We1 r10 in the same cycle -> r10 stays busy.
- Trace (GPR_MP_TRACE_EN defined): dual write to r7 -> exactly one line printed, showing port 1 and data 0x22.
